systolic_array_controller: RTL
==============================

# systolic_array_controller

Sequencer for a ROWS x COLS weight-stationary array of processing elements. It clears the array, loads weights from the weight buffer and streams activation vectors from the activation buffer. It then drains the skewed pipeline and flags per-column partial-sum validity for the output collector. It sits between the accelerator's command interface and the PE array, and drives each array's shared LOAD, EN and SYNC_RST controls.

## Interface
- ROWS, 4, PE rows (reduction depth)
- COLS, 4, PE columns (weights per row; one weight-buffer word per column)
- VEC_W, 8, width of vector count
- ADDR_W, 10, buffer address width (must be >= VEC_W and >= clog2(COLS))

- CLK  in  1  clock, rising edge
- ASYNC_RST  in  1  asynchronous, active-low reset
- start  in  1  command strobe; accepted only in IDLE
- num_vecs  in  VEC_W  activation vectors to process; captured when start is accepted
- abort  in  1  cancel the running job
- busy  out  1  controller not in IDLE
- done  out  1  one-cycle completion pulse
- w_rd_en  out  1  weight-buffer read
- w_addr  out  ADDR_W  weight-buffer address
- a_rd_en  out  1  activation-buffer read
- a_addr  out  ADDR_W  activation-buffer address
- SYNC_RST  out  1  array synchronous clear
- LOAD  out  1  array weight load
- EN  out  1  array compute enable
- act_zero  out  1  force zero activations into the array (drain)
- out_col_valid  out  COLS  bit j: PsumOut of column j holds a valid result this cycle
- perf_cycles  out  32  busy-cycle count (see Configuration)

## Operation
- FSM states and durations:
  - IDLE
  - CLEAR: 1 cycle
  - LOAD_W: COLS cycles
  - COMPUTE: N cycles
  - DRAIN: ROWS+COLS-1 cycles
  - DONE: 1 cycle
  - DONE then returns to IDLE.
- IDLE -> CLEAR requires start=1 and num_vecs != 0. If start=1 with num_vecs == 0, the command is ignored and the controller stays in IDLE.
- N is the captured num_vecs. Later changes to num_vecs have no effect on the running job.
- LOAD_W: w_rd_en=1, w_addr=0..COLS-1, incrementing by 1 per cycle.
- COMPUTE: a_rd_en=1, a_addr=0..N-1, incrementing by 1 per cycle.
- DRAIN: no buffer reads; act_zero path active.
- Outside their states, the rd_en signals are 0 and the addresses are 0.
- busy = (state != IDLE). done = (state == DONE).
- Array-side outputs are registered from state and lag it by exactly one cycle, matching the 1-cycle buffer read latency:
  - SYNC_RST follows CLEAR.
  - LOAD follows LOAD_W.
  - EN follows COMPUTE or DRAIN.
  - act_zero follows DRAIN.
- Let e be the 0-based index of EN-high cycles within the job. out_col_valid[j] = 1 for ROWS+j <= e <= ROWS+j+N-1, and 0 otherwise.
- abort in any non-IDLE state:
  - Next state is IDLE.
  - A one-cycle SYNC_RST pulse follows (lagged by one cycle).
  - LOAD, EN, act_zero and out_col_valid go to 0 on that lagged cycle.
  - done is not asserted.
- abort in IDLE is ignored. start and abort in the same IDLE cycle: start is accepted.
- start while busy is ignored. It is not queued.
- Counters use internal widths sufficient for N up to 2^VEC_W-1 and for the drain length. Addresses never wrap within a job.

## Timing
- Reset values:
  - state = IDLE
  - all outputs 0, including perf_cycles and out_col_valid
  - internal counters 0
- Reset mid-job: immediate return to IDLE with all outputs 0. No SYNC_RST pulse is generated; the array has its own reset.
- Start acceptance: start is sampled at edge k and the CLEAR state occupies cycle k+1.
- Job length in state cycles: 1 + COLS + N + ROWS + COLS - 1 + 1.
- The last EN cycle coincides with the done cycle.
- Back-to-back jobs: start asserted during the done cycle is ignored, because that cycle is still busy. The earliest new start is accepted in the first IDLE cycle.

## Configuration
- SA_CTRL_PERF_CNT_EN defined:
  - perf_cycles counts the cycles with busy=1, saturating at 2^32-1.
  - It clears to 0 when start is accepted and holds its value after done or abort.
- SA_CTRL_PERF_CNT_EN undefined: perf_cycles is tied to 0 and no counter logic is built.

## Test plan
- Reset and idle: reset low for 2 cycles mid-job, then released → all outputs 0, busy=0. No activity without start.
- Nominal job (ROWS=COLS=4, N=3):
  - busy high for 16 cycles.
  - w_addr 0,1,2,3, then a_addr 0,1,2.
  - LOAD high for 4 cycles and EN high for 10 cycles, each lagging its state by 1.
  - out_col_valid[0] high at e=4..6 and out_col_valid[3] high at e=7..9.
  - done in the 16th busy cycle; perf_cycles=16 when SA_CTRL_PERF_CNT_EN is defined, else 0.
- Illegal command: start with num_vecs=0 → busy stays 0, no reads issued.
- Abort during COMPUTE (N=5, abort at the 2nd COMPUTE cycle) → IDLE next cycle, one SYNC_RST pulse, EN 0, no done.
- Start while busy and at the done cycle → ignored. A start on the next IDLE cycle runs a fresh job with a_addr restarting at 0.
- Maximum N (N=255): addresses reach 254 without wrap; out_col_valid[3] stays high for 255 cycles.

Source files
------------

// File: rtl/systolic_array_controller.sv
// Weight-stationary systolic array sequencer: clear, weight load, activation stream, drain.
// Optional busy-cycle counter is built when SA_CTRL_PERF_CNT_EN is defined.
module systolic_array_controller #(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int VEC_W  = 8,
    parameter int ADDR_W = 10
) (
    input  logic              CLK,
    input  logic              ASYNC_RST,
    input  logic              start,
    input  logic [VEC_W-1:0]  num_vecs,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              w_rd_en,
    output logic [ADDR_W-1:0] w_addr,
    output logic              a_rd_en,
    output logic [ADDR_W-1:0] a_addr,
    output logic              SYNC_RST,
    output logic              LOAD,
    output logic              EN,
    output logic              act_zero,
    output logic [COLS-1:0]   out_col_valid,
    output logic [31:0]       perf_cycles
);

    localparam int CW = VEC_W + $clog2(ROWS + COLS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD_W,
        S_COMPUTE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    e_cnt;
    logic [VEC_W-1:0] n_reg;
    logic             in_cd;
    logic             kill;

    assign in_cd = (state == S_COMPUTE) || (state == S_DRAIN);
    assign kill  = (state != S_IDLE) && abort;

    // Buffer-side outputs are registered from the next state; array-side ones lag the current state.
    always_ff @(posedge CLK or negedge ASYNC_RST) begin
        if (!ASYNC_RST) begin
            state         <= S_IDLE;
            cnt           <= '0;
            e_cnt         <= '0;
            n_reg         <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            w_rd_en       <= 1'b0;
            w_addr        <= '0;
            a_rd_en       <= 1'b0;
            a_addr        <= '0;
            SYNC_RST      <= 1'b0;
            LOAD          <= 1'b0;
            EN            <= 1'b0;
            act_zero      <= 1'b0;
            out_col_valid <= '0;
        end else begin
            SYNC_RST <= (state == S_CLEAR) || kill;
            LOAD     <= (state == S_LOAD_W) && !kill;
            EN       <= in_cd && !kill;
            act_zero <= (state == S_DRAIN) && !kill;
            for (int unsigned j = 0; j < COLS; j++) begin
                out_col_valid[j] <= in_cd && !kill
                                    && (e_cnt >= CW'(ROWS + j))
                                    && (e_cnt < CW'(ROWS + j) + CW'(n_reg));
            end
            e_cnt <= (in_cd && !kill) ? e_cnt + CW'(1) : '0;

            w_rd_en <= 1'b0;
            w_addr  <= '0;
            a_rd_en <= 1'b0;
            a_addr  <= '0;
            done    <= 1'b0;

            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (start && (num_vecs != '0)) begin
                        n_reg <= num_vecs;
                        state <= S_CLEAR;
                        busy  <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    state   <= S_LOAD_W;
                    cnt     <= '0;
                    w_rd_en <= 1'b1;
                end
                S_LOAD_W: begin
                    if (cnt == CW'(COLS - 1)) begin
                        state   <= S_COMPUTE;
                        cnt     <= '0;
                        a_rd_en <= 1'b1;
                    end else begin
                        cnt     <= cnt + CW'(1);
                        w_rd_en <= 1'b1;
                        w_addr  <= ADDR_W'(cnt + CW'(1));
                    end
                end
                S_COMPUTE: begin
                    if (cnt == CW'(n_reg) - CW'(1)) begin
                        state <= S_DRAIN;
                        cnt   <= '0;
                    end else begin
                        cnt     <= cnt + CW'(1);
                        a_rd_en <= 1'b1;
                        a_addr  <= ADDR_W'(cnt + CW'(1));
                    end
                end
                S_DRAIN: begin
                    if (cnt == CW'(ROWS + COLS - 2)) begin
                        state <= S_DONE;
                        cnt   <= '0;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase

            if (kill) begin
                state   <= S_IDLE;
                cnt     <= '0;
                busy    <= 1'b0;
                done    <= 1'b0;
                w_rd_en <= 1'b0;
                w_addr  <= '0;
                a_rd_en <= 1'b0;
                a_addr  <= '0;
            end
        end
    end

`ifdef SA_CTRL_PERF_CNT_EN
    always_ff @(posedge CLK or negedge ASYNC_RST) begin
        if (!ASYNC_RST) begin
            perf_cycles <= '0;
        end else if (state == S_IDLE) begin
            if (start && (num_vecs != '0)) perf_cycles <= '0;
        end else if (perf_cycles != '1) begin
            perf_cycles <= perf_cycles + 32'd1;
        end
    end
`else
    assign perf_cycles = '0;
`endif

endmodule
